// File: rtl/spi_xfer_sequencer.sv
// Flash-style SPI transaction sequencer: frames cmd/address/dummy/data bytes onto the
// master byte engine and round-robin arbitrates it between the CSR path and the loader.
module spi_xfer_sequencer #(
    parameter int pAdrsBytes = 3,
    parameter int pLenBit    = 16,
    parameter int pCsGap     = 4
) (
    input  logic               iSysClk,
    input  logic               iSysRst,
    input  logic               iSPIEn,
    input  logic [1:0]         iReq,
    input  logic [7:0]         iCmd0,
    input  logic [7:0]         iCmd1,
    input  logic [31:0]        iAdrs0,
    input  logic [31:0]        iAdrs1,
    input  logic [3:0]         iDummy0,
    input  logic [3:0]         iDummy1,
    input  logic [pLenBit-1:0] iLen0,
    input  logic [pLenBit-1:0] iLen1,
    input  logic               iDir0,
    input  logic               iDir1,
    input  logic [7:0]         iWd,
    output logic [1:0]         oGnt,
    output logic               oWdAck,
    output logic [7:0]         oRd,
    output logic               oRVd,
    output logic [1:0]         oDone,
    output logic               oErr,
    output logic               oBusy,
    output logic [7:0]         oByteWd,
    output logic               oByteStart,
    input  logic               iByteDone,
    input  logic [7:0]         iByteRd,
    output logic               oSpiCs
);

    localparam int AW = pAdrsBytes * 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_CMD   = 3'd2;
    localparam logic [2:0] S_ADR   = 3'd3;
    localparam logic [2:0] S_DUMMY = 3'd4;
    localparam logic [2:0] S_DATA  = 3'd5;
    localparam logic [2:0] S_CSEND = 3'd6;
    localparam logic [2:0] S_GAP   = 3'd7;

    localparam logic [pLenBit-1:0] LEN_ONE  = {{(pLenBit-1){1'b0}}, 1'b1};
    localparam logic [pLenBit-1:0] LEN_ZERO = '0;
    localparam logic [3:0]         GAP_LAST = 4'(pCsGap - 1);
    localparam logic [1:0]         ADR_LAST = 2'(pAdrsBytes - 1);

    logic [2:0]         state_q, state_d;
    logic [1:0]         gnt_q, gnt_d;
    logic               last_q, last_d;
    logic               cs_q, cs_d;
    logic               err_q, err_d;
    logic               pend_q, pend_d;
    logic               dir_q, dir_d;
    logic [pLenBit-1:0] len_q, len_d;
    logic [3:0]         dum_q, dum_d;
    logic [1:0]         idx_q, idx_d;
    logic [3:0]         gap_q, gap_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [AW-1:0]      adr_q, adr_d;

    logic       in_phase, active, xfer, got, abort, win;
    logic [7:0] byte_sel;

    assign in_phase = (state_q == S_CMD) || (state_q == S_ADR) ||
                      (state_q == S_DUMMY) || (state_q == S_DATA);
    assign active   = (state_q != S_IDLE) && (state_q != S_GAP);
    assign xfer     = in_phase && !pend_q && iSPIEn;
    // Only a done that answers our own outstanding start counts; strays are dropped.
    assign got      = in_phase && pend_q && iByteDone && iSPIEn;
    assign abort    = active && !iSPIEn;
    assign win      = (iReq == 2'b11) ? ~last_q : iReq[1];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cs_d    = cs_q;
        err_d   = err_q;
        pend_d  = pend_q;
        dir_d   = dir_q;
        len_d   = len_q;
        dum_d   = dum_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        cmd_d   = cmd_q;
        adr_d   = adr_q;

        if (xfer) pend_d = 1'b1;
        if (got)  pend_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (iSPIEn && (iReq != 2'b00)) begin
                    state_d = S_GRANT;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    last_d  = win;
                    cs_d    = 1'b1;
                    err_d   = 1'b0;
                    pend_d  = 1'b0;
                    idx_d   = 2'd0;
                    cmd_d   = win ? iCmd1 : iCmd0;
                    adr_d   = win ? iAdrs1[AW-1:0] : iAdrs0[AW-1:0];
                    dum_d   = win ? iDummy1 : iDummy0;
                    len_d   = win ? iLen1 : iLen0;
                    dir_d   = win ? iDir1 : iDir0;
                end
            end
            S_GRANT: state_d = S_CMD;
            S_CMD: begin
                if (got) state_d = S_ADR;
            end
            S_ADR: begin
                if (got) begin
                    adr_d = adr_q << 8;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == ADR_LAST) begin
                        if (dum_q != 4'd0)         state_d = S_DUMMY;
                        else if (len_q != LEN_ZERO) state_d = S_DATA;
                        else                        state_d = S_CSEND;
                    end
                end
            end
            S_DUMMY: begin
                if (got) begin
                    dum_d = dum_q - 4'd1;
                    if (dum_q == 4'd1) state_d = (len_q != LEN_ZERO) ? S_DATA : S_CSEND;
                end
            end
            S_DATA: begin
                if (got) begin
                    len_d = len_q - LEN_ONE;
                    if (len_q == LEN_ONE) state_d = S_CSEND;
                end
            end
            S_CSEND: begin
                state_d = S_GAP;
                cs_d    = 1'b0;
                gap_d   = GAP_LAST;
            end
            default: begin
                if (gap_q == 4'd0) begin
                    state_d = S_IDLE;
                    gnt_d   = 2'b00;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
        endcase

        if (abort) begin
            state_d = S_GAP;
            cs_d    = 1'b0;
            pend_d  = 1'b0;
            err_d   = 1'b1;
            gap_d   = GAP_LAST;
        end
    end

    always_ff @(posedge iSysClk or negedge iSysRst) begin
        if (!iSysRst) begin
            state_q <= S_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            cs_q    <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            dir_q   <= 1'b0;
            len_q   <= '0;
            dum_q   <= 4'd0;
            idx_q   <= 2'd0;
            gap_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cs_q    <= cs_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            dir_q   <= dir_d;
            len_q   <= len_d;
            dum_q   <= dum_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
        end
    end

    // Byte payload registers; every output use is qualified by state, so no reset needed.
    always_ff @(posedge iSysClk) begin
        cmd_q <= cmd_d;
        adr_q <= adr_d;
    end

    always_comb begin
        byte_sel = 8'h00;
        case (state_q)
            S_CMD:   byte_sel = cmd_q;
            S_ADR:   byte_sel = adr_q[AW-1 -: 8];
            S_DATA:  byte_sel = dir_q ? iWd : 8'h00;
            default: byte_sel = 8'h00;
        endcase
    end

    assign oGnt       = gnt_q;
    assign oBusy      = |gnt_q;
    assign oSpiCs     = cs_q;
    assign oByteStart = xfer;
    assign oByteWd    = xfer ? byte_sel : 8'h00;
    assign oWdAck     = xfer && (state_q == S_DATA) && dir_q;
    assign oRVd       = got && (state_q == S_DATA) && !dir_q;
    assign oRd        = oRVd ? iByteRd : 8'h00;
    assign oDone      = ((state_q == S_GAP) && (gap_q == 4'd0)) ? gnt_q : 2'b00;
    assign oErr       = (oDone != 2'b00) && err_q;

endmodule
